// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC blocks: quadrant tags, angle unit and
// default parameters for the quadrant-folding wrapper.
package cordic_pkg;

  // Angles are carried in hundredths of a degree by every CORDIC core.
  localparam int ANG_UNIT_PER_DEG = 100;

  localparam int ANG90_DEF   = 90 * ANG_UNIT_PER_DEG;
  localparam int XY_LIM_DEF  = 16383;
  localparam int LATENCY_DEF = 9;

  // Quadrant tag: number of +90 degree steps removed by the fold.
  typedef logic signed [1:0] qtag_t;
  localparam qtag_t TAG_ZERO = 2'sb00;
  localparam qtag_t TAG_POS  = 2'sb01;
  localparam qtag_t TAG_NEG  = 2'sb11;

  // Side information that travels alongside a sample through the core.
  typedef struct packed {
    logic  vld;
    qtag_t tag;
    logic  sat;
  } tag_info_t;

  typedef enum logic {
    ST_FLUSH = 1'b0,
    ST_RUN   = 1'b1
  } fold_state_t;

endpackage

// File: rtl/cordic_tag_delay.sv
// Fixed-depth shift line for {valid, tag, sat} with synchronous clear, used to
// line side information up with the CORDIC core result.
module cordic_tag_delay
  import cordic_pkg::*;
#(
  parameter int STAGES = LATENCY_DEF + 1
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      clr,
  input  tag_info_t d_i,
  output tag_info_t q_o
);

  tag_info_t line_q [STAGES];

  // Shift one stage per cycle; reset or clear empties every stage.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < STAGES; i++) line_q[i] <= '0;
    end else begin
      line_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) line_q[i] <= line_q[i-1];
    end
  end

  assign q_o = line_q[STAGES-1];

endmodule

// File: rtl/cordic_quad_fold.sv
// Quadrant fold around a vectoring CORDIC core: clips and rotates the input
// into the right half-plane, then restores the full-circle angle on the way out.
module cordic_quad_fold
  import cordic_pkg::*;
#(
  parameter int LATENCY = LATENCY_DEF,
  parameter int ANG90   = ANG90_DEF,
  parameter int XY_LIM  = XY_LIM_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] in_x,
  input  logic signed [15:0] in_y,
  output logic signed [15:0] core_x,
  output logic signed [15:0] core_y,
  input  logic signed [15:0] core_r,
  input  logic signed [15:0] core_ang,
  output logic               out_valid,
  output logic signed [15:0] out_r,
  output logic signed [15:0] out_ang,
  output logic               out_sat
);

  localparam int DATA_W = 16;
  localparam int CNT_W  = $clog2(LATENCY + 2);
  localparam logic signed [DATA_W-1:0] LIM_P   = DATA_W'(XY_LIM);
  localparam logic signed [DATA_W:0]   ANG90_P = (DATA_W + 1)'(ANG90);

  function automatic logic signed [DATA_W-1:0] clip_xy(input logic signed [DATA_W-1:0] v);
    if (v > LIM_P)       return LIM_P;
    else if (v < -LIM_P) return -LIM_P;
    else                 return v;
  endfunction

  function automatic logic signed [DATA_W-1:0] sat_ang(input logic signed [DATA_W:0] v);
    if (v > 17'sd32767)       return 16'sh7FFF;
    else if (v < -17'sd32768) return 16'sh8000;
    else                      return v[DATA_W-1:0];
  endfunction

  fold_state_t              state_q;
  logic [CNT_W-1:0]         cnt_q;
  logic                     in_ready_q;
  logic signed [DATA_W-1:0] core_x_q, core_y_q;
  logic signed [DATA_W-1:0] core_x_d, core_y_d;
  logic signed [DATA_W-1:0] x_clip, y_clip;
  qtag_t                    tag_d;
  logic                     sat_d;
  logic                     accept;
  tag_info_t                line_d, line_q;
  logic signed [DATA_W:0]   ang_off, ang_sum;
  logic                     out_valid_q, out_sat_q;
  logic signed [DATA_W-1:0] out_r_q, out_ang_q;

  assign accept = in_valid && in_ready_q && !clr && !rst;

  // Clip both inputs (so negation can never overflow), then fold into x >= 0.
  always_comb begin
    x_clip   = clip_xy(in_x);
    y_clip   = clip_xy(in_y);
    sat_d    = (x_clip != in_x) || (y_clip != in_y);
    core_x_d = x_clip;
    core_y_d = y_clip;
    tag_d    = TAG_ZERO;
    if (x_clip[DATA_W-1]) begin
      if (!y_clip[DATA_W-1]) begin
        core_x_d = y_clip;
        core_y_d = -x_clip;
        tag_d    = TAG_POS;
      end else begin
        core_x_d = -y_clip;
        core_y_d = x_clip;
        tag_d    = TAG_NEG;
      end
    end
    line_d     = '0;
    line_d.vld = accept;
    line_d.tag = accept ? tag_d : TAG_ZERO;
    line_d.sat = accept && sat_d;
  end

  // Flush/run control: FLUSH waits out LATENCY+1 cycles of zeros through the core.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q    <= ST_FLUSH;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_FLUSH: begin
          if (cnt_q == CNT_W'(LATENCY)) begin
            state_q    <= ST_RUN;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_RUN:  in_ready_q <= 1'b1;
        default: begin
          state_q    <= ST_FLUSH;
          cnt_q      <= '0;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Stage p0 -> core: present the folded sample, zeros when nothing is accepted.
  always_ff @(posedge clk) begin
    if (rst || !accept) begin
      core_x_q <= '0;
      core_y_q <= '0;
    end else begin
      core_x_q <= core_x_d;
      core_y_q <= core_y_d;
    end
  end

  cordic_tag_delay #(
    .STAGES (LATENCY + 1)
  ) u_tag_delay (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .d_i (line_d),
    .q_o (line_q)
  );

  // Undo the fold: add back the removed quarter turns at 17 bits.
  always_comb begin
    ang_off = '0;
    case (line_q.tag)
      TAG_POS: ang_off = ANG90_P;
      TAG_NEG: ang_off = -ANG90_P;
      default: ang_off = '0;
    endcase
    ang_sum = $signed({core_ang[DATA_W-1], core_ang}) + ang_off;
  end

  // Output stage: capture on valid, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_r_q     <= '0;
      out_ang_q   <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      out_valid_q <= line_q.vld && !clr;
      if (line_q.vld && !clr) begin
        out_r_q   <= core_r;
        out_ang_q <= sat_ang(ang_sum);
        out_sat_q <= line_q.sat;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign core_x    = core_x_q;
  assign core_y    = core_y_q;
  assign out_valid = out_valid_q;
  assign out_r     = out_r_q;
  assign out_ang   = out_ang_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_cordic_quad_fold.sv
// Directed bench for cordic_quad_fold with a behavioural 9-cycle vectoring core.
module tb_cordic_quad_fold;

  localparam int LAT = 9;

  logic clk = 1'b0;
  logic rst, clr, in_valid, in_ready, out_valid, out_sat;
  logic signed [15:0] in_x, in_y, core_x, core_y, core_r, core_ang, out_r, out_ang;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cordic_quad_fold #(
    .LATENCY (LAT),
    .ANG90   (9000),
    .XY_LIM  (16383)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .core_x    (core_x),
    .core_y    (core_y),
    .core_r    (core_r),
    .core_ang  (core_ang),
    .out_valid (out_valid),
    .out_r     (out_r),
    .out_ang   (out_ang),
    .out_sat   (out_sat)
  );

  // Behavioural vectoring core: norm and atan2 in 0.01 degree, LAT cycles deep.
  function automatic logic signed [15:0] m_r(input logic signed [15:0] x, input logic signed [15:0] y);
    real xr, yr;
    xr = x;
    yr = y;
    return 16'($rtoi($sqrt(xr * xr + yr * yr) + 0.5));
  endfunction

  function automatic logic signed [15:0] m_ang(input logic signed [15:0] x, input logic signed [15:0] y);
    real xr, yr, a;
    xr = x;
    yr = y;
    a  = $atan2(yr, xr) * 18000.0 / 3.141592653589793;
    if (a >= 0.0) return 16'($rtoi(a + 0.5));
    else          return 16'($rtoi(a - 0.5));
  endfunction

  logic signed [15:0] mr [LAT];
  logic signed [15:0] ma [LAT];

  always @(posedge clk) begin
    mr[0] <= m_r(core_x, core_y);
    ma[0] <= m_ang(core_x, core_y);
    for (int i = 1; i < LAT; i++) begin
      mr[i] <= mr[i-1];
      ma[i] <= ma[i-1];
    end
  end

  assign core_r   = mr[LAT-1];
  assign core_ang = ma[LAT-1];

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input int x, input int y);
    in_valid = v;
    in_x     = 16'(x);
    in_y     = 16'(y);
  endtask

  // Bounded wait for out_valid; n counts cycles since the sample was driven.
  task automatic wait_out(input int start, output int n);
    n = start;
    while (out_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    int early;
    tick();
    tick();
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || core_x !== 16'sd0 || core_y !== 16'sd0 ||
        out_r !== 16'sd0 || out_ang !== 16'sd0 || out_sat !== 1'b0) begin
      bad++;
      $display("FAIL reset_state rdy=%b ov=%b cx=%0d cy=%0d r=%0d ang=%0d sat=%b want all 0",
               in_ready, out_valid, core_x, core_y, out_r, out_ang, out_sat);
    end
    rst = 1'b0;
    early = 0;
    for (int i = 0; i < 10; i++) begin
      if (in_ready !== 1'b0 || out_valid !== 1'b0) early++;
      tick();
    end
    total++;
    if (early != 0) begin
      bad++;
      $display("FAIL reset_flush_window got %0d busy-window violations want 0", early);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready_after_flush got %b want 1", in_ready);
    end
  endtask

  task automatic test_single();
    int n, a, r;
    drive(1'b1, -1000, 1000);
    tick();
    drive(1'b0, 0, 0);
    total++;
    if (core_x !== 16'sd1000 || core_y !== 16'sd1000) begin
      bad++;
      $display("FAIL single_core got (%0d,%0d) want (1000,1000)", core_x, core_y);
    end
    tick();
    total++;
    if (core_x !== 16'sd0 || core_y !== 16'sd0) begin
      bad++;
      $display("FAIL single_core_idle got (%0d,%0d) want (0,0)", core_x, core_y);
    end
    wait_out(2, n);
    total++;
    if (n != 11 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL single_latency got %0d want 11", n);
    end
    a = out_ang;
    r = out_r;
    total++;
    if (iabs(a - 13500) > 50 || iabs(r - 1414) > 2 || out_sat !== 1'b0) begin
      bad++;
      $display("FAIL single_result got ang=%0d r=%0d sat=%b want ~13500 ~1414 0", a, r, out_sat);
    end
    tick();
    total++;
    if (out_valid !== 1'b0 || out_ang !== 16'(a) || out_r !== 16'(r)) begin
      bad++;
      $display("FAIL single_hold got ov=%b ang=%0d r=%0d want 0 %0d %0d", out_valid, out_ang, out_r, a, r);
    end
  endtask

  task automatic test_back_to_back();
    int xs [4] = '{1000, -1000, -1000, 1000};
    int ys [4] = '{500, 500, -500, -500};
    int ea [4] = '{2657, 15343, -15343, -2657};
    int n, a, r;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, xs[i], ys[i]);
      tick();
    end
    drive(1'b0, 0, 0);
    wait_out(4, n);
    total++;
    if (n != 11) begin
      bad++;
      $display("FAIL b2b_latency got %0d want 11", n);
    end
    for (int i = 0; i < 4; i++) begin
      a = out_ang;
      r = out_r;
      total++;
      if (out_valid !== 1'b1 || iabs(a - ea[i]) > 50 || iabs(r - 1118) > 2) begin
        bad++;
        $display("FAIL b2b_q%0d got ov=%b ang=%0d r=%0d want 1 ~%0d ~1118", i, out_valid, a, r, ea[i]);
      end
      tick();
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_end got %b want 0", out_valid);
    end
  endtask

  task automatic test_sat();
    int n, a, r;
    drive(1'b1, -32768, 20000);
    tick();
    drive(1'b0, 0, 0);
    total++;
    if (core_x !== 16'sd16383 || core_y !== 16'sd16383) begin
      bad++;
      $display("FAIL sat_core_a got (%0d,%0d) want (16383,16383)", core_x, core_y);
    end
    wait_out(1, n);
    a = out_ang;
    r = out_r;
    total++;
    if (n != 11 || out_sat !== 1'b1 || iabs(a - 13500) > 50 || iabs(r - 23169) > 2) begin
      bad++;
      $display("FAIL sat_result_a got n=%0d sat=%b ang=%0d r=%0d want 11 1 ~13500 ~23169", n, out_sat, a, r);
    end
    drive(1'b1, -5, -32768);
    tick();
    drive(1'b0, 0, 0);
    total++;
    if (core_x !== 16'sd16383 || core_y !== -16'sd5) begin
      bad++;
      $display("FAIL sat_core_b got (%0d,%0d) want (16383,-5)", core_x, core_y);
    end
    wait_out(1, n);
    a = out_ang;
    total++;
    if (n != 11 || out_sat !== 1'b1 || iabs(a + 9002) > 50) begin
      bad++;
      $display("FAIL sat_result_b got n=%0d sat=%b ang=%0d want 11 1 ~-9002", n, out_sat, a);
    end
    drive(1'b1, 16383, -16383);
    tick();
    drive(1'b0, 0, 0);
    total++;
    if (core_x !== 16'sd16383 || core_y !== -16'sd16383) begin
      bad++;
      $display("FAIL lim_core got (%0d,%0d) want (16383,-16383)", core_x, core_y);
    end
    wait_out(1, n);
    a = out_ang;
    total++;
    if (n != 11 || out_sat !== 1'b0 || iabs(a + 4500) > 50) begin
      bad++;
      $display("FAIL lim_result got n=%0d sat=%b ang=%0d want 11 0 ~-4500", n, out_sat, a);
    end
  endtask

  task automatic test_clr();
    int n, a, r, viol, seen;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1000, i * 100);
      tick();
    end
    clr = 1'b1;
    drive(1'b1, -1000, 1000);
    tick();
    clr = 1'b0;
    drive(1'b0, 0, 0);
    total++;
    if (core_x !== 16'sd0 || core_y !== 16'sd0) begin
      bad++;
      $display("FAIL clr_not_accepted got (%0d,%0d) want (0,0)", core_x, core_y);
    end
    viol = 0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (in_ready !== 1'b0) viol++;
      if (out_valid !== 1'b0) seen++;
      tick();
    end
    total++;
    if (viol != 0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL clr_flush got %0d early-ready cycles, ready=%b want 0 and 1", viol, in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      if (out_valid !== 1'b0) seen++;
      tick();
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL clr_discard got %0d out_valid pulses want 0", seen);
    end
    drive(1'b1, 1000, 0);
    tick();
    drive(1'b0, 0, 0);
    wait_out(1, n);
    a = out_ang;
    r = out_r;
    total++;
    if (n != 11 || iabs(a) > 50 || iabs(r - 1000) > 2) begin
      bad++;
      $display("FAIL clr_next got n=%0d ang=%0d r=%0d want 11 ~0 ~1000", n, a, r);
    end
  endtask

  task automatic test_rst_priority();
    int viol, seen;
    drive(1'b1, -1000, 1000);
    tick();
    drive(1'b0, 0, 0);
    tick();
    tick();
    rst = 1'b1;
    clr = 1'b1;
    drive(1'b1, -1000, 1000);
    tick();
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || core_x !== 16'sd0 || core_y !== 16'sd0 ||
        out_r !== 16'sd0 || out_ang !== 16'sd0 || out_sat !== 1'b0) begin
      bad++;
      $display("FAIL rst_priority rdy=%b ov=%b cx=%0d cy=%0d r=%0d ang=%0d sat=%b want all 0",
               in_ready, out_valid, core_x, core_y, out_r, out_ang, out_sat);
    end
    rst = 1'b0;
    clr = 1'b0;
    drive(1'b0, 0, 0);
    viol = 0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (in_ready !== 1'b0) viol++;
      if (out_valid !== 1'b0) seen++;
      tick();
    end
    total++;
    if (viol != 0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_recover got %0d early-ready cycles, ready=%b want 0 and 1", viol, in_ready);
    end
    for (int i = 0; i < 15; i++) begin
      if (out_valid !== 1'b0) seen++;
      tick();
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL rst_discard got %0d out_valid pulses want 0", seen);
    end
  endtask

  initial begin
    rst = 1'b1;
    clr = 1'b0;
    drive(1'b0, 0, 0);
    test_reset();
    test_single();
    test_back_to_back();
    test_sat();
    test_clr();
    test_rst_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cordic_quad_fold.md
CORDIC_QUAD_FOLD -- requirements
Module: cordic_quad_fold

Interface
REQ-001 Parameter LATENCY, default 9: cycles from a folded sample on core_x/core_y to its result on core_r/core_ang.
REQ-002 Parameter ANG90, default 9000: 90 degrees in the core's angle unit (0.01 degree).
REQ-003 Parameter XY_LIM, default 16383: maximum input magnitude the core accepts without first-stage overflow.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 clr  in  1  synchronous soft flush request.
REQ-007 in_valid  in  1  input sample present.
REQ-008 in_ready  out  1  block accepts a sample this cycle.
REQ-009 in_x, in_y  in  16 signed  raw vector.
REQ-010 core_x, core_y  out  16 signed  folded vector to the vectoring CORDIC core; registered.
REQ-011 core_r, core_ang  in  16 signed  raw norm and angle from the core.
REQ-012 out_valid  out  1  corrected result present; one-cycle pulse per accepted sample.
REQ-013 out_r, out_ang  out  16 signed  norm and full-circle angle in 0.01 degree, range -18000..+18000.
REQ-014 out_sat  out  1  input of this result was clipped.

Function
REQ-015 FSM states: FLUSH and RUN. in_ready SHALL be 1 only in RUN.
- FLUSH: drive core_x = core_y = 0; count LATENCY+1 cycles; then go to RUN.
- RUN: accept a sample every cycle in which in_valid = 1.
REQ-016 clr in any state SHALL enter FLUSH, restart the count, and clear every tag/valid stage. A sample presented in the same cycle as clr is not accepted.
REQ-017 Saturation: each of in_x, in_y SHALL clip to -XY_LIM..+XY_LIM before folding. sat = 1 if either input clipped.
REQ-018 Folding rules:
- x >= 0: (x, y) passed unchanged, tag 0.
- x < 0, y >= 0: (y, -x), tag +1.
- x < 0, y < 0: (-y, x), tag -1.
REQ-019 An accepted sample at cycle T SHALL appear on core_x/core_y at T+1. Without an accepted sample, both SHALL be 0.
REQ-020 A shift line of depth LATENCY+1 SHALL carry {valid, tag, sat} from T so that it aligns with core_r/core_ang at T+1+LATENCY.
REQ-021 At T+2+LATENCY the block SHALL register:
- out_r = core_r
- out_ang = core_ang + tag*ANG90, computed at 17 bits, then saturated to 16 bits
- out_sat = delayed sat
- out_valid = delayed valid
REQ-022 When out_valid = 0, out_r, out_ang and out_sat SHALL hold their last values.
REQ-023 Back-to-back samples SHALL produce back-to-back out_valid pulses in the same order; throughput is 1 sample per cycle.
REQ-024 in_x = -32768 or in_y = -32768 SHALL clip to -XY_LIM and never overflow on negation.

Reset
REQ-025 rst SHALL:
- force state to FLUSH with a zero count;
- clear core_x, core_y, out_r, out_ang, out_sat, out_valid, in_ready and the whole shift line to 0.
REQ-026 rst takes priority over clr and in_valid. Samples in flight at reset SHALL be discarded and never produce out_valid.

Structure
REQ-027 A shared package cordic_pkg SHALL hold:
- the quadrant-tag encoding (2-bit signed);
- default values for ANG90, XY_LIM and LATENCY;
- the angle-unit constant, also used by the rotation and vectoring cores.
REQ-028 One sub-module, cordic_tag_delay, SHALL implement the parameterised {valid, tag, sat} shift line with synchronous clear.

Verification
REQ-029 rst for 2 cycles, then release -> in_ready = 0 for exactly LATENCY+1 = 10 cycles, then 1; out_valid stays 0 throughout.
REQ-030 In RUN, drive in_x = -1000, in_y = 1000 against a behavioural core model (LATENCY 9) -> core_x = 1000, core_y = 1000 one cycle later; out_valid at T+11 with out_ang ~= 13500 (+/-50) and out_r ~= 1414.
REQ-031 Stream 4 back-to-back samples, one in each quadrant ((1000,500), (-1000,500), (-1000,-500), (1000,-500)) -> 4 consecutive out_valid pulses with angles ~2657, ~15343, ~-15343 and ~-2657.
REQ-032 Drive in_x = -32768, in_y = 20000 -> core inputs (16383, 16383); out_sat = 1 on the matching result.
REQ-033 Assert clr while 3 samples are in flight -> no out_valid for them; in_ready low for 10 cycles; the next sample completes normally.
REQ-034 Assert rst in the same cycle as in_valid = 1 and clr = 1 -> sample not accepted and all outputs 0 on the next cycle.
